hp48_bus_responder: RTL and testbench

// - Target (slave) end of the hp48 nibble bus: answers the initiator's bus commands.
// - Keeps its own PC and DP pointers, a configured base address and a nibble memory.
// - Sits on hp48_bus beside the ROM; first instance is a 2^ADDR_BITS-nibble RAM.
// - Multiple instances chain via daisy_in/daisy_out for CONFIGURE ordering.

---
 rtl/hp48_bus_responder_pkg.sv | 34 +++
 rtl/hp48_bus_responder_if.sv | 22 ++
 rtl/hp48_bus_responder_nibble_ram.sv | 20 ++
 rtl/hp48_bus_responder.sv | 114 +++++++++++
 tb/tb_hp48_bus_responder.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/hp48_bus_responder_pkg.sv
// hp48 bus responder: shared bus command encodings and window helper.
// Imported by the responder top and the bench; no ports.
package hp48_bus_responder_pkg;

    typedef enum logic [3:0] {
        BUSCMD_NOP       = 4'h0,
        BUSCMD_ID        = 4'h1,
        BUSCMD_PC_READ   = 4'h2,
        BUSCMD_DP_READ   = 4'h3,
        BUSCMD_PC_WRITE  = 4'h4,
        BUSCMD_DP_WRITE  = 4'h5,
        BUSCMD_LOAD_PC   = 4'h6,
        BUSCMD_LOAD_DP   = 4'h7,
        BUSCMD_CONFIGURE = 4'h8,
        BUSCMD_UNCNFG    = 4'h9,
        BUSCMD_RESET     = 4'hF
    } bus_cmd_e;

    localparam int ADDR_W = 20;

    // Pointer is inside the window when its distance above base,
    // taken modulo 2^20, fits in the window size.
    function automatic logic in_window(
        input logic [ADDR_W-1:0] ptr,
        input logic [ADDR_W-1:0] base,
        input logic              cfg,
        input int                bits
    );
        logic [ADDR_W-1:0] d;
        d = ptr - base;
        return cfg && ((d >> bits) == '0);
    endfunction

endpackage

// File: rtl/hp48_bus_responder_if.sv
// hp48 nibble bus: strobe/command/address/nibble_in from the initiator,
// nibble_out/active back from the target. master = initiator, slave = target.
interface hp48_bus_responder_if;
    import hp48_bus_responder_pkg::*;

    logic              strobe;
    logic [3:0]        command;
    logic [ADDR_W-1:0] address;
    logic [3:0]        nibble_in;
    logic [3:0]        nibble_out;
    logic              active;

    modport master (
        output strobe, command, address, nibble_in,
        input  nibble_out, active
    );

    modport slave (
        input  strobe, command, address, nibble_in,
        output nibble_out, active
    );
endinterface

// File: rtl/hp48_bus_responder_nibble_ram.sv
// hp48_nibble_ram: 2^ADDR_BITS x 4 memory, one sync write, one sync read.
// Ports: clk, we/waddr/wdata, re/raddr, rdata (holds when re=0). No reset.
module hp48_nibble_ram #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [3:0]           wdata,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [3:0]           rdata
);
    logic [3:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/hp48_bus_responder.sv
// hp48 bus responder: target end of the nibble bus with PC/DP, base, ID.
// Ports: clk, reset, bus (slave modport), daisy_in, daisy_out, configured.
module hp48_bus_responder
    import hp48_bus_responder_pkg::*;
#(
    parameter int          ADDR_BITS  = 10,
    parameter logic [19:0] ID_CODE    = 20'h00019,
    parameter bit          FIXED_BASE = 1'b0,
    parameter logic [19:0] BASE_ADDR  = 20'h00000
) (
    input  logic                   clk,
    input  logic                   reset,
    hp48_bus_responder_if.slave    bus,
    input  logic                   daisy_in,
    output logic                   daisy_out,
    output logic                   configured
);
    localparam logic [19:0] RST_BASE = FIXED_BASE ? BASE_ADDR : 20'h0;

    logic [19:0] base, pc, dp;
    logic [2:0]  id_idx;
    logic [3:0]  id_nib;
    logic        src_ram;
    logic        act_q;

    bus_cmd_e    cmd;
    logic        rst_all;
    logic        use_dp;
    logic [19:0] ptr, diff, id_sh;
    logic        hit, addr_hit;
    logic        is_rd, is_wr;
    logic [3:0]  ram_q;

    assign cmd      = bus_cmd_e'(bus.command);
    assign rst_all  = reset || (bus.strobe && cmd == BUSCMD_RESET);
    assign use_dp   = (cmd == BUSCMD_DP_READ) || (cmd == BUSCMD_DP_WRITE);
    assign ptr      = use_dp ? dp : pc;
    assign diff     = ptr - base;
    assign hit      = in_window(ptr, base, configured, ADDR_BITS);
    assign addr_hit = in_window(bus.address, base, configured, ADDR_BITS);
    assign id_sh    = ID_CODE >> {id_idx, 2'b00};

    assign is_rd = bus.strobe && !reset && hit &&
                   (cmd == BUSCMD_PC_READ || cmd == BUSCMD_DP_READ);
    assign is_wr = bus.strobe && !reset && hit &&
                   (cmd == BUSCMD_PC_WRITE || cmd == BUSCMD_DP_WRITE);

    hp48_nibble_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
        .clk   (clk),
        .we    (is_wr),
        .waddr (diff[ADDR_BITS-1:0]),
        .wdata (bus.nibble_in),
        .re    (is_rd),
        .raddr (diff[ADDR_BITS-1:0]),
        .rdata (ram_q)
    );

    // Output is whichever source answered last; both sources hold.
    assign bus.nibble_out = src_ram ? ram_q : id_nib;
    assign bus.active     = act_q;
    assign daisy_out      = daisy_in & configured;

    always_ff @(posedge clk) begin
        act_q <= 1'b0;
        if (rst_all) begin
            configured <= FIXED_BASE;
            base       <= RST_BASE;
            pc         <= '0;
            dp         <= '0;
            id_idx     <= '0;
            id_nib     <= '0;
            src_ram    <= 1'b0;
        end else if (bus.strobe) begin
            unique case (cmd)
                BUSCMD_ID: begin
                    if (daisy_in && !configured) begin
                        id_nib  <= id_sh[3:0];
                        src_ram <= 1'b0;
                        act_q   <= 1'b1;
                        id_idx  <= (id_idx == 3'd4) ? 3'd0 : id_idx + 3'd1;
                    end
                end
                BUSCMD_PC_READ, BUSCMD_DP_READ,
                BUSCMD_PC_WRITE, BUSCMD_DP_WRITE: begin
                    if (is_rd) begin
                        src_ram <= 1'b1;
                        act_q   <= 1'b1;
                    end
                    if (use_dp) dp <= dp + 20'd1;
                    else        pc <= pc + 20'd1;
                end
                BUSCMD_LOAD_PC: begin
                    pc     <= bus.address;
                    id_idx <= '0;
                end
                BUSCMD_LOAD_DP: begin
                    dp     <= bus.address;
                    id_idx <= '0;
                end
                BUSCMD_CONFIGURE: begin
                    if (!FIXED_BASE && daisy_in && !configured) begin
                        base <= {bus.address[19:ADDR_BITS],
                                 {ADDR_BITS{1'b0}}};
                        configured <= 1'b1;
                    end
                end
                BUSCMD_UNCNFG: begin
                    if (!FIXED_BASE && addr_hit) configured <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hp48_bus_responder.sv
// Bench for hp48_bus_responder: spec-level model checked every cycle,
// plus directed literal expectations from the documented scenarios.
module tb_hp48_bus_responder;
    localparam logic [19:0] ID = 20'h00019;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic daisy_in = 1'b1;
    logic daisy_out, configured;

    hp48_bus_responder_if bif ();

    hp48_bus_responder #(
        .ADDR_BITS  (10),
        .ID_CODE    (ID),
        .FIXED_BASE (1'b0),
        .BASE_ADDR  (20'h00000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bif),
        .daisy_in   (daisy_in),
        .daisy_out  (daisy_out),
        .configured (configured)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- model ----------------
    logic [3:0]  mm [int];
    int unsigned m_pc, m_dp, m_base, m_id;
    bit          m_cfg, m_act, m_known, m_valid;
    logic [3:0]  m_nib;

    function automatic bit mhit(input int unsigned p);
        return m_cfg && (((p - m_base) & 32'hFFFFF) < 1024);
    endfunction

    always @(posedge clk) begin : model
        int unsigned p, off;
        logic [3:0] c;
        c = bif.command;
        m_act = 0;
        if (reset || (bif.strobe && c == 4'hF)) begin
            m_cfg = 0; m_base = 0; m_pc = 0; m_dp = 0; m_id = 0;
            m_nib = 0; m_known = 1; m_valid = 1;
        end else if (bif.strobe) begin
            case (c)
                4'h1: if (daisy_in && !m_cfg) begin
                    m_nib = 4'((ID >> (4 * m_id)) & 20'hF);
                    m_known = 1; m_act = 1;
                    m_id = (m_id + 1) % 5;
                end
                4'h2, 4'h3, 4'h4, 4'h5: begin
                    p = (c == 4'h2 || c == 4'h4) ? m_pc : m_dp;
                    off = (p - m_base) & 32'h3FF;
                    if (mhit(p)) begin
                        if (c == 4'h4 || c == 4'h5) mm[off] = bif.nibble_in;
                        else begin
                            m_act = 1;
                            m_known = mm.exists(off);
                            if (m_known) m_nib = mm[off];
                        end
                    end
                    p = (p + 1) % 32'h100000;
                    if (c == 4'h2 || c == 4'h4) m_pc = p; else m_dp = p;
                end
                4'h6: begin m_pc = bif.address; m_id = 0; end
                4'h7: begin m_dp = bif.address; m_id = 0; end
                4'h8: if (daisy_in && !m_cfg) begin
                    m_base = bif.address - (bif.address % 1024);
                    m_cfg = 1;
                end
                4'h9: if (mhit(bif.address)) m_cfg = 0;
                default: ;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [19:0] got,
                       input logic [19:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model.active", 20'(bif.active), 20'(m_act));
            chk("model.configured", 20'(configured), 20'(m_cfg));
            chk("model.daisy_out", 20'(daisy_out), 20'(m_cfg & daisy_in));
            if (m_known) chk("model.nibble", 20'(bif.nibble_out), 20'(m_nib));
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic s, input logic [3:0] c,
                        input logic [19:0] a, input logic [3:0] n);
        @(posedge clk); #2;
        bif.strobe = s; bif.command = c; bif.address = a; bif.nibble_in = n;
    endtask

    // Issue one command then idle; on return outputs reflect the command.
    task automatic op(input logic [3:0] c, input logic [19:0] a,
                      input logic [3:0] n);
        send(1'b1, c, a, n);
        send(1'b0, 4'h0, 20'h0, 4'h0);
    endtask

    task automatic lit(input string nm, input logic a, input logic [3:0] n);
        chk({nm, ".active"}, 20'(bif.active), 20'(a));
        if (a) chk({nm, ".nibble"}, 20'(bif.nibble_out), 20'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] idv [5];
        logic [3:0] abc [3];
        idv = '{4'h9, 4'h1, 4'h0, 4'h0, 4'h0};
        abc = '{4'hA, 4'hB, 4'hC};
        m_valid = 0;
        send(1'b0, 4'h0, 20'h0, 4'h0);
        send(1'b0, 4'h0, 20'h0, 4'h0);
        reset = 1'b0;
        send(1'b0, 4'h0, 20'h0, 4'h0);
        chk("rst.nibble", 20'(bif.nibble_out), 20'h0);
        chk("rst.active", 20'(bif.active), 20'h0);
        chk("rst.configured", 20'(configured), 20'h0);

        for (int i = 0; i < 5; i++) begin
            op(4'h1, 20'h0, 4'h0);
            lit("id", 1'b1, idv[i]);
        end

        op(4'h8, 20'h80123, 4'h0);
        chk("cfg.configured", 20'(configured), 20'h1);
        chk("cfg.daisy_out", 20'(daisy_out), 20'h1);
        op(4'h1, 20'h0, 4'h0);
        lit("id_after_cfg", 1'b0, 4'h0);

        op(4'h7, 20'h80010, 4'h0);
        for (int i = 0; i < 3; i++) op(4'h5, 20'h0, abc[i]);
        op(4'h6, 20'h80010, 4'h0);
        for (int i = 0; i < 3; i++) begin
            op(4'h2, 20'h0, 4'h0);
            lit("rd_abc", 1'b1, abc[i]);
        end

        op(4'h7, 20'h803FF, 4'h0);
        op(4'h5, 20'h0, 4'h5);
        op(4'h6, 20'h803FF, 4'h0);
        op(4'h2, 20'h0, 4'h0);
        lit("edge_in", 1'b1, 4'h5);
        op(4'h2, 20'h0, 4'h0);
        lit("edge_out", 1'b0, 4'h0);
        chk("edge_hold", 20'(bif.nibble_out), 20'h5);

        op(4'h6, 20'hFFFFF, 4'h0);
        op(4'h2, 20'h0, 4'h0);
        lit("wrap", 1'b0, 4'h0);

        op(4'h9, 20'h80200, 4'h0);
        chk("uncnfg", 20'(configured), 20'h0);
        daisy_in = 1'b0;
        op(4'h8, 20'h00000, 4'h0);
        chk("cfg_nodaisy", 20'(configured), 20'h0);
        daisy_in = 1'b1;

        // Base 0 now: pc wrapped to 00000, so a PC_READ sees DP's write.
        op(4'h8, 20'h00000, 4'h0);
        op(4'h7, 20'h00000, 4'h0);
        op(4'h5, 20'h0, 4'h7);
        op(4'h2, 20'h0, 4'h0);
        lit("wrap_pc0", 1'b1, 4'h7);

        op(4'hF, 20'h0, 4'h0);
        chk("rstcmd.cfg", 20'(configured), 20'h0);
        chk("rstcmd.nibble", 20'(bif.nibble_out), 20'h0);
        op(4'h8, 20'h80000, 4'h0);
        op(4'h6, 20'h80011, 4'h0);
        op(4'h2, 20'h0, 4'h0);
        lit("mem_kept", 1'b1, 4'hB);

        op(4'h6, 20'h80010, 4'h0);
        send(1'b1, 4'h2, 20'h0, 4'h0);
        reset = 1'b1;
        send(1'b0, 4'h0, 20'h0, 4'h0);
        reset = 1'b0;
        chk("rst_rd.active", 20'(bif.active), 20'h0);
        chk("rst_rd.cfg", 20'(configured), 20'h0);
        send(1'b0, 4'h0, 20'h0, 4'h0);
        send(1'b0, 4'h0, 20'h0, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
